tri_input_conditioner: RTL
==========================

// Module: tri_input_conditioner
// PURPOSE
//   Upstream conditioner for the 3-input truth-table gate modules (in1,in2,in3).
//   Synchronises three asynchronous raw inputs, then debounces the 3-bit vector.
//   Only a vector held stable for STABLE_CYCLES is committed to in1..in3.
//   Pulses `changed` on every commit and counts rejected glitches.
// PARAMETERS
//   SYNC_STAGES    2       synchroniser flops per bit; legal >= 2
//   STABLE_CYCLES  4       consecutive identical samples required to commit; legal >= 1
//   RESET_VALUE    3'b000  value of {in1,in2,in3} after reset
// PORTS
//   clk        in   1  single clock; all flops rising-edge
//   rst_n      in   1  asynchronous active-low reset
//   raw_in     in   3  asynchronous inputs; [2]->in1, [1]->in2, [0]->in3
//   freeze     in   1  1 = block commits and abort any pending candidate
//   clr_stats  in   1  synchronous clear of glitch_cnt
//   in1        out  1  committed bit 2 (registered)
//   in2        out  1  committed bit 1 (registered)
//   in3        out  1  committed bit 0 (registered)
//   changed    out  1  one-cycle pulse in the cycle after a commit
//   glitch_cnt out  8  saturating count of aborted candidates
// BEHAVIOUR
// - Reset (async assert, sync-safe release):
//   - sync flops = 0; {in1,in2,in3} = RESET_VALUE; changed = 0; glitch_cnt = 0.
//   - state = STABLE; cnt = 0; cand = RESET_VALUE.
//   - Reset mid-PENDING discards the candidate without counting it as a glitch.
// - Signals:
//   - s = output of the last synchroniser stage.
//   - commit_v = {in1,in2,in3}.
// - FSM, evaluated on every edge:
//   - STABLE:
//     - s == commit_v or freeze = 1: stay; cnt = 0.
//     - Otherwise, with STABLE_CYCLES == 1: commit s immediately; stay in STABLE.
//     - Otherwise: go to PENDING; cand = s; cnt = 1.
//   - PENDING:
//     - freeze = 1: go to STABLE; cnt = 0; glitch_cnt += 1.
//     - s == cand and cnt == STABLE_CYCLES-1: commit_v = cand; go to STABLE; cnt = 0.
//     - s == cand (otherwise): cnt += 1.
//     - s == commit_v: go to STABLE; cnt = 0; glitch_cnt += 1.
//     - Any other s: cand = s; cnt = 1; glitch_cnt += 1.
// - Commit:
//   - in1..in3 update on the commit edge.
//   - changed = 1 for exactly the following cycle.
//   - Back-to-back commits give back-to-back pulses.
// - Latency: a clean raw change committed at edge SYNC_STAGES+STABLE_CYCLES after
//   the first capturing edge (default 6).
// - glitch_cnt:
//   - Saturates at 255.
//   - clr_stats has priority over a same-cycle increment (result 0).
// - Width of cnt: $clog2(STABLE_CYCLES+1); cnt never exceeds STABLE_CYCLES-1.
// - freeze does not stall the synchronisers.
//   - Deasserting freeze while s != commit_v enters PENDING on the next edge
//     with cnt = 1.
// - Outputs never glitch: all outputs come directly from flops.
// TESTING
// - Reset: rst_n=0 mid-cycle with RESET_VALUE=3'b101 -> in1,in2,in3=1,0,1 at once;
//   changed=0; glitch_cnt=0.
// - Clean change: raw_in 000->011 held 10 cycles (defaults) -> {in1,in2,in3}=011
//   at edge 6; changed high only in cycle 7.
// - Bounce: raw_in 000->100 for 2 cycles, back to 000 -> no commit; changed
//   never 1; glitch_cnt=1.
// - Candidate swap: 000->001 for 2 cycles, then 010 held -> glitch_cnt=1;
//   010 committed 4 cycles after s first shows 010.
// - Freeze: freeze=1 with raw_in=111 held 20 cycles -> outputs unchanged;
//   freeze=0 -> 111 committed after 4 edges.
// - Saturation/clear: 300 aborted candidates -> glitch_cnt=255; clr_stats with a
//   coincident abort -> 0.

Source files
------------

// File: rtl/tri_input_conditioner.sv
// Synchronises and debounces three asynchronous inputs. A vector is committed
// to in1..in3 only after it has been held stable. Aborted candidates are counted.
module tri_input_conditioner #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter logic [2:0]  RESET_VALUE   = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] raw_in,
   input  logic       freeze,
   input  logic       clr_stats,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       changed,
   output logic [7:0] glitch_cnt
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic {STABLE, PENDING} state_t;

   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [2:0]                    cand_q, cand_d;
   logic [2:0]                    commit_q, commit_d;
   logic [SYNC_STAGES-1:0][2:0]   sync_q;
   logic [2:0]                    s;
   logic                          do_commit;
   logic                          glitch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cand_d    = cand_q;
      commit_d  = commit_q;
      do_commit = 1'b0;
      glitch    = 1'b0;
      case (state_q)
         STABLE: begin
            cnt_d = '0;
            if (s != commit_q && !freeze) begin
               // A single required sample means the first differing sample commits.
               if (STABLE_CYCLES == 1) begin
                  commit_d  = s;
                  do_commit = 1'b1;
               end else begin
                  state_d = PENDING;
                  cand_d  = s;
                  cnt_d   = CW'(1);
               end
            end
         end
         PENDING: begin
            if (freeze) begin
               state_d = STABLE;
               cnt_d   = '0;
               glitch  = 1'b1;
            end else if (s == cand_q) begin
               if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                  commit_d  = cand_q;
                  do_commit = 1'b1;
                  state_d   = STABLE;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (s == commit_q) begin
               state_d = STABLE;
               cnt_d   = '0;
               glitch  = 1'b1;
            end else begin
               cand_d = s;
               cnt_d  = CW'(1);
               glitch = 1'b1;
            end
         end
         default: begin
            state_d = STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= STABLE;
         cnt_q      <= '0;
         cand_q     <= RESET_VALUE;
         commit_q   <= RESET_VALUE;
         changed    <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cand_q   <= cand_d;
         commit_q <= commit_d;
         changed  <= do_commit;
         if (clr_stats) begin
            glitch_cnt <= '0;
         end else if (glitch && glitch_cnt != 8'hFF) begin
            glitch_cnt <= glitch_cnt + 8'd1;
         end
      end
   end

   assign in1 = commit_q[2];
   assign in2 = commit_q[1];
   assign in3 = commit_q[0];

endmodule
